bpm_peak_detect: RTL and testbench
==================================

Name: bpm_peak_detect

Overview:
- Parametrised per-channel peak detector for the BPM ADC path. Sits after the ADC deserializer and before the position-calculation stage.
- For each data-valid window, reports per channel:
  - the peak magnitude;
  - the sample index where the peak first occurred;
  - an overflow flag.
- Adds over the previous generation: an N-channel generic width, an absolute-magnitude mode, peak-position output, window sample count and truncation flag, back-to-back windows, and a sticky overflow with clear.

Parameters:
- NUM_CH, 4, number of ADC channels packed in data_in.
- ADC_W, 16, ADC sample width (two's complement).
- IDX_W, 12, width of the sample index and sample counter.
- ADC_TH, 30000, overflow threshold on magnitude; must be < 2^(ADC_W-1).
- ABS_MODE, 0, 0 = positive peaks only; 1 = absolute-magnitude peaks.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  high while window samples are present; one sample per cycle.
- data_in  in  NUM_CH*ADC_W  channel k occupies bits [k*ADC_W +: ADC_W].
- ovf_clr  in  1  synchronous clear of ovf_sticky.
- peak_out  out  NUM_CH*ADC_W  latched peak magnitude per channel, zero-extended, same packing as data_in.
- peak_idx  out  NUM_CH*IDX_W  latched sample index of each peak.
- overflow  out  NUM_CH  latched per-channel peak > ADC_TH.
- ovf_sticky  out  NUM_CH  OR of overflow across windows until ovf_clr.
- sample_count  out  IDX_W  number of samples in the last window (saturating).
- truncated  out  1  last window exceeded 2^IDX_W-1 samples.
- result_valid  out  1  one-cycle strobe; all result outputs are updated on the same edge.
- busy  out  1  high in ACQ and DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs and internal trackers go to 0; state goes to IDLE.
  - A window in progress is abandoned and produces no result_valid.
- States: IDLE, ACQ, DONE.
  - IDLE: when in_valid=1, go to ACQ. That same sample is processed as index 0 (the first sample is not dropped).
  - ACQ: process each in_valid=1 sample. The first edge with in_valid=0 goes to DONE.
  - DONE: lasts exactly one cycle. On this edge:
    - latch trackers to the outputs;
    - pulse result_valid=1 for one cycle;
    - OR overflow into ovf_sticky.
    - If in_valid=1 in this cycle, a new window starts: go to ACQ, trackers are reinitialised with this sample as index 0. Otherwise go to IDLE.
- Latency: last sample at cycle N, in_valid low at N+1, DONE at N+2, result_valid high during N+3.
- Window init: tracker magnitude=0, index=0, counter=0. This is the same as reset, except that the sample being accepted on that edge is applied.
- Magnitude:
  - ABS_MODE=0: mag = x when the sign bit is 0, else the sample is ignored.
  - ABS_MODE=1: mag = |x|; the most-negative code saturates to 2^(ADC_W-1)-1.
  - Result width is ADC_W-1.
- Update rule: strict mag > current peak, so ties keep the earliest index. A window of all-ignored or all-zero samples reports peak 0, idx 0.
- Counter: counts accepted samples and saturates at 2^IDX_W-1. The sample arriving while the counter is already saturated sets truncated. Samples past saturation still update the peak, and their index is clamped to 2^IDX_W-1.
- Overflow is computed from the newly latched peak, not from the previous window.
- ovf_clr:
  - clears ovf_sticky on the same edge;
  - if it coincides with DONE, the new window's overflow bits are still set (set wins).
- Outputs hold between result_valid strobes.

Decomposition:
- Package bpm_pkg holds:
  - the state enum (IDLE/ACQ/DONE);
  - a function abs_sat(x) for saturating magnitude;
  - a localparam default for ADC_TH.
- Sub-module bpm_peak_ch: one channel's magnitude, compare, peak/index registers and overflow compare. Generated NUM_CH times.
- The top level holds the FSM, the sample counter, the sticky logic and the output latches.

Test Plan:
- ABS_MODE=0: ch0 window {100, 500, 300, -2000} in_valid 4 cycles → result_valid once, 3 cycles after the last sample. Expected peak=500, idx=1, sample_count=4, overflow=0.
- ABS_MODE=1: ch1 {-32768, 10, 32767} → peak=32767, idx=0 (tie keeps earliest), overflow=1, ovf_sticky[1]=1.
- Back-to-back windows:
  - {7, 9} then in_valid low 1 cycle, then {3} starting in the DONE cycle.
  - First result: peak=9, idx=1. Second result: peak=3, idx=0, sample_count=1.
- 4100-sample window with IDX_W=12 and a peak at sample 4096 → sample_count=4095, truncated=1, peak_idx=4095.
- rst asserted mid-window after 5 samples → all outputs 0 immediately, no result_valid. The next window reports correctly from index 0.
- ovf_clr:
  - ovf_clr with no DONE pending → ovf_sticky cleared.
  - ovf_clr coincident with DONE of an overflowing window (ch2 sample 31000) → ovf_sticky[2]=1.

Source files
------------

// File: rtl/bpm_pkg.sv
// Shared types and helpers for the BPM per-channel peak detector.
package bpm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DONE = 2'd2
  } bpm_state_e;

  localparam int ADC_TH_DEF = 30000;

  // |x| clamped to the largest positive code of a w-bit sample, so the
  // most-negative code maps to 2^(w-1)-1.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int w);
    logic [31:0] a;
    logic [31:0] lim;
    lim = (32'd1 << (w - 1)) - 32'd1;
    a   = x[31] ? 32'(-x) : 32'(x);
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/bpm_peak_ch.sv
// One channel: magnitude, strict-greater compare, peak/index trackers and
// the overflow compare on the tracked peak.
module bpm_peak_ch
  import bpm_pkg::*;
#(
  parameter int ADC_W    = 16,
  parameter int IDX_W    = 12,
  parameter int ADC_TH   = ADC_TH_DEF,
  parameter int ABS_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             smp_en,
  input  logic             start,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [ADC_W-1:0] x,
  output logic [ADC_W-2:0] peak,
  output logic [IDX_W-1:0] idx,
  output logic             ovf
);

  logic [ADC_W-2:0] mag, base, peak_q, peak_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    if (ABS_MODE != 0) mag = (ADC_W-1)'(abs_sat(32'(signed'(x)), ADC_W));
    else               mag = x[ADC_W-1] ? '0 : x[ADC_W-2:0];
    // a window start compares against a fresh zero tracker
    base   = start ? '0 : peak_q;
    peak_d = peak_q;
    idx_d  = idx_q;
    if (smp_en) begin
      if (start) begin
        peak_d = '0;
        idx_d  = '0;
      end
      if (mag > base) begin
        peak_d = mag;
        idx_d  = cur_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_q <= '0;
      idx_q  <= '0;
    end else begin
      peak_q <= peak_d;
      idx_q  <= idx_d;
    end
  end

  assign peak = peak_q;
  assign idx  = idx_q;
  assign ovf  = 32'(peak_q) > 32'(ADC_TH);

endmodule

// File: rtl/bpm_peak_detect.sv
// N-channel windowed peak detector: FSM, sample counter, result latches
// and sticky overflow around an array of per-channel trackers.
module bpm_peak_detect
  import bpm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADC_W    = 16,
  parameter int IDX_W    = 12,
  parameter int ADC_TH   = ADC_TH_DEF,
  parameter int ABS_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [NUM_CH*ADC_W-1:0] data_in,
  input  logic                    ovf_clr,
  output logic [NUM_CH*ADC_W-1:0] peak_out,
  output logic [NUM_CH*IDX_W-1:0] peak_idx,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       ovf_sticky,
  output logic [IDX_W-1:0]        sample_count,
  output logic                    truncated,
  output logic                    result_valid,
  output logic                    busy
);

  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  bpm_state_e state_q, state_d;
  logic smp_en, start, done;

  logic [IDX_W-1:0] cnt_q, cnt_d, cur_idx;
  logic             trunc_q, trunc_d;

  logic [NUM_CH-1:0][ADC_W-2:0] ch_peak;
  logic [NUM_CH-1:0][IDX_W-1:0] ch_idx;
  logic [NUM_CH-1:0]            ch_ovf;

  logic [NUM_CH-1:0][ADC_W-1:0] peak_out_q, peak_out_d;
  logic [NUM_CH-1:0][IDX_W-1:0] peak_idx_q, peak_idx_d;
  logic [NUM_CH-1:0]            overflow_q, overflow_d;
  logic [NUM_CH-1:0]            sticky_q, sticky_d;
  logic [IDX_W-1:0]             count_q, count_d;
  logic                         trunc_out_q, trunc_out_d;
  logic                         rv_q, rv_d;

  always_comb begin
    state_d = state_q;
    smp_en  = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = ACQ;
        smp_en  = 1'b1;
        start   = 1'b1;
      end
      ACQ: begin
        if (in_valid) smp_en  = 1'b1;
        else          state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (in_valid) begin
          state_d = ACQ;
          smp_en  = 1'b1;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // counter holds the index of the next sample; once saturated, later
  // samples reuse the clamped index and flag truncation
  always_comb begin
    cur_idx = start ? '0 : cnt_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    if (smp_en) begin
      if (start) begin
        cnt_d   = IDX_W'(1);
        trunc_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
        trunc_d = 1'b1;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    bpm_peak_ch #(
      .ADC_W   (ADC_W),
      .IDX_W   (IDX_W),
      .ADC_TH  (ADC_TH),
      .ABS_MODE(ABS_MODE)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .smp_en (smp_en),
      .start  (start),
      .cur_idx(cur_idx),
      .x      (data_in[k*ADC_W +: ADC_W]),
      .peak   (ch_peak[k]),
      .idx    (ch_idx[k]),
      .ovf    (ch_ovf[k])
    );
  end

  // trackers still hold the closed window on the DONE edge, even if a
  // new window is being started on that same edge
  always_comb begin
    peak_out_d  = peak_out_q;
    peak_idx_d  = peak_idx_q;
    overflow_d  = overflow_q;
    count_d     = count_q;
    trunc_out_d = trunc_out_q;
    rv_d        = done;
    sticky_d    = ovf_clr ? '0 : sticky_q;
    if (done) begin
      for (int k = 0; k < NUM_CH; k++) peak_out_d[k] = {1'b0, ch_peak[k]};
      peak_idx_d  = ch_idx;
      overflow_d  = ch_ovf;
      count_d     = cnt_q;
      trunc_out_d = trunc_q;
      sticky_d    = sticky_d | ch_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      trunc_q     <= 1'b0;
      peak_out_q  <= '0;
      peak_idx_q  <= '0;
      overflow_q  <= '0;
      sticky_q    <= '0;
      count_q     <= '0;
      trunc_out_q <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trunc_q     <= trunc_d;
      peak_out_q  <= peak_out_d;
      peak_idx_q  <= peak_idx_d;
      overflow_q  <= overflow_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
      trunc_out_q <= trunc_out_d;
      rv_q        <= rv_d;
    end
  end

  assign peak_out     = peak_out_q;
  assign peak_idx     = peak_idx_q;
  assign overflow     = overflow_q;
  assign ovf_sticky   = sticky_q;
  assign sample_count = count_q;
  assign truncated    = trunc_out_q;
  assign result_valid = rv_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bpm_peak_detect.sv
// Drives one stimulus stream into a positive-peak and an absolute-magnitude
// instance and compares both against a window-level reference model.
module tb_bpm_peak_detect;
  localparam int NC   = 4;
  localparam int AW   = 16;
  localparam int IW   = 12;
  localparam int TH   = 30000;
  localparam int CMAX = (1 << IW) - 1;
  localparam int PMAX = (1 << (AW - 1)) - 1;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, ovf_clr = 1'b0;
  logic [NC*AW-1:0] data_in = '0;

  logic [NC*AW-1:0] pk[2];
  logic [NC*IW-1:0] ix[2];
  logic [NC-1:0]    ov[2], st[2];
  logic [IW-1:0]    cn[2];
  logic             tr[2], rv[2], by[2];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    bpm_peak_detect #(.NUM_CH(NC), .ADC_W(AW), .IDX_W(IW), .ADC_TH(TH), .ABS_MODE(m)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .ovf_clr(ovf_clr),
      .peak_out(pk[m]), .peak_idx(ix[m]), .overflow(ov[m]), .ovf_sticky(st[m]),
      .sample_count(cn[m]), .truncated(tr[m]), .result_valid(rv[m]), .busy(by[m])
    );
  end

  // reference state: expected visible outputs plus the open window
  logic [NC*AW-1:0] e_pk[2], r_pk[2];
  logic [NC*IW-1:0] e_ix[2], r_ix[2];
  logic [NC-1:0]    e_ov[2], r_ov[2], e_st[2];
  logic [IW-1:0]    e_cn[2], r_cn[2];
  logic             e_tr[2], r_tr[2], e_rv;
  logic [NC*AW-1:0] win_q[$];
  bit               pend;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int mag(input int mode, input logic [AW-1:0] s);
    int x;
    x = int'(signed'(s));
    if (mode == 0) return (x < 0) ? 0 : x;
    if (x < 0) x = -x;
    return (x > PMAX) ? PMAX : x;
  endfunction

  function automatic void calc(input int mode);
    int n, bp, bi, mv;
    n = win_q.size();
    for (int c = 0; c < NC; c++) begin
      bp = 0; bi = 0;
      for (int i = 0; i < n; i++) begin
        mv = mag(mode, win_q[i][c*AW +: AW]);
        if (mv > bp) begin bp = mv; bi = (i > CMAX) ? CMAX : i; end
      end
      r_pk[mode][c*AW +: AW] = AW'(bp);
      r_ix[mode][c*IW +: IW] = IW'(bi);
      r_ov[mode][c]          = (bp > TH);
    end
    r_cn[mode] = IW'((n > CMAX) ? CMAX : n);
    r_tr[mode] = (n > CMAX);
  endfunction

  task automatic model_clear();
    win_q.delete();
    pend = 0; e_rv = 0;
    for (int m = 0; m < 2; m++) begin
      e_pk[m] = '0; e_ix[m] = '0; e_ov[m] = '0; e_st[m] = '0; e_cn[m] = '0; e_tr[m] = 0;
    end
  endtask

  // one clock edge: a result lands two edges after its window's last sample
  task automatic model_edge(input logic v, input logic [NC*AW-1:0] d, input logic clr);
    e_rv = 0;
    for (int m = 0; m < 2; m++) if (clr) e_st[m] = '0;
    if (pend) begin
      e_rv = 1; pend = 0;
      for (int m = 0; m < 2; m++) begin
        e_pk[m] = r_pk[m]; e_ix[m] = r_ix[m]; e_ov[m] = r_ov[m];
        e_cn[m] = r_cn[m]; e_tr[m] = r_tr[m]; e_st[m] = e_st[m] | r_ov[m];
      end
    end
    if (v) win_q.push_back(d);
    else if (win_q.size() > 0) begin
      calc(0); calc(1);
      win_q.delete();
      pend = 1;
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d_peak", m), 64'(pk[m]), 64'(e_pk[m]));
      chk($sformatf("m%0d_idx", m), 64'(ix[m]), 64'(e_ix[m]));
      chk($sformatf("m%0d_ovf", m), 64'(ov[m]), 64'(e_ov[m]));
      chk($sformatf("m%0d_sticky", m), 64'(st[m]), 64'(e_st[m]));
      chk($sformatf("m%0d_count", m), 64'(cn[m]), 64'(e_cn[m]));
      chk($sformatf("m%0d_trunc", m), 64'(tr[m]), 64'(e_tr[m]));
      chk($sformatf("m%0d_rv", m), 64'(rv[m]), 64'(e_rv));
      chk($sformatf("m%0d_busy", m), 64'(by[m]), 64'(win_q.size() > 0 || pend));
    end
  endtask

  task automatic step(input logic v, input logic [NC*AW-1:0] d, input logic clr);
    in_valid = v; data_in = d; ovf_clr = clr;
    @(posedge clk);
    model_edge(v, d, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    in_valid = 1'b0; ovf_clr = 1'b0;
    #1 model_clear();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    check_all();
  endtask

  function automatic logic [NC*AW-1:0] rnd_vec(input int amp);
    logic [NC*AW-1:0] d;
    for (int c = 0; c < NC; c++) d[c*AW +: AW] = AW'(int'($urandom_range(2 * amp)) - amp);
    return d;
  endfunction

  function automatic logic [NC*AW-1:0] set_ch(input logic [NC*AW-1:0] d, input int c, input int val);
    logic [NC*AW-1:0] r;
    r = d;
    r[c*AW +: AW] = AW'(val);
    return r;
  endfunction

  int tp[$];
  logic [NC*AW-1:0] dv;

  initial begin
    model_clear();
    #3 rst = 1'b0;
    #2 check_all();
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    idle(2);

    tp = '{100, 500, 300, -2000};
    foreach (tp[i]) step(1'b1, set_ch(rnd_vec(50), 0, tp[i]), 1'b0);
    idle(4);
    chk("tp_pos_peak", 64'(pk[0][15:0]), 64'd500);
    chk("tp_pos_idx", 64'(ix[0][11:0]), 64'd1);
    chk("tp_pos_count", 64'(cn[0]), 64'd4);

    tp = '{-32768, 10, 32767};
    foreach (tp[i]) step(1'b1, set_ch(rnd_vec(1000), 1, tp[i]), 1'b0);
    idle(4);
    chk("tp_abs_peak", 64'(pk[1][31:16]), 64'd32767);
    chk("tp_abs_idx", 64'(ix[1][23:12]), 64'd0);
    chk("tp_abs_sticky", 64'(st[1][1]), 64'd1);

    step(1'b1, set_ch(rnd_vec(5), 3, 7), 1'b0);
    step(1'b1, set_ch(rnd_vec(5), 3, 9), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, set_ch(rnd_vec(5), 3, 3), 1'b0);
    chk("b2b_first_peak", 64'(pk[0][63:48]), 64'd9);
    chk("b2b_first_idx", 64'(ix[0][47:36]), 64'd1);
    idle(4);
    chk("b2b_second_peak", 64'(pk[0][63:48]), 64'd3);
    chk("b2b_second_count", 64'(cn[0]), 64'd1);

    step(1'b0, '0, 1'b1);
    chk("clr_idle_sticky", 64'(st[1]), 64'd0);

    step(1'b1, set_ch(rnd_vec(1000), 2, 31000), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("clr_done_sticky", 64'(st[0][2]), 64'd1);
    idle(2);

    for (int i = 0; i < 5; i++) step(1'b1, rnd_vec(20000), 1'b0);
    do_reset();
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b1, rnd_vec(20000), 1'b0);
    idle(4);
    chk("post_rst_count", 64'(cn[0]), 64'd3);

    for (int i = 0; i < 4100; i++) begin
      dv = rnd_vec(15000);
      if (i == 4096) for (int c = 0; c < NC; c++) dv = set_ch(dv, c, 20000);
      step(1'b1, dv, 1'b0);
    end
    idle(4);
    chk("trunc_count", 64'(cn[0]), 64'd4095);
    chk("trunc_flag", 64'(tr[0]), 64'd1);
    chk("trunc_idx", 64'(ix[0][11:0]), 64'd4095);

    for (int w = 0; w < 60; w++) begin
      int len = int'($urandom_range(20, 1));
      int gap = int'($urandom_range(3, 1));
      for (int i = 0; i < len; i++) begin
        for (int c = 0; c < NC; c++) dv[c*AW +: AW] = AW'($urandom);
        step(1'b1, dv, ($urandom_range(7) == 0));
      end
      for (int i = 0; i < gap; i++) step(1'b0, '0, ($urandom_range(7) == 0));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
